alu_pipe: RTL and testbench

Parametrised, fully pipelined type-1 ALU (no load/store) for the RMT action stage. It decodes the opcode in each sub-action, computes the result from two PHV operands or one operand and an immediate, and returns the container together with a carry/borrow flag. It accepts one action per cycle, and its output latency is configurable. It sits between sub_action extraction and PHV re-assembly, and it supports output backpressure.

---
 rtl/alu_defs.sv | 37 +++
 rtl/alu_delay_line.sv | 50 +++++
 rtl/alu_pipe.sv | 123 ++++++++++++
 tb/tb_alu_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
`default_nettype none
// ============================================================================
// Package     : alu_defs
// Description : Opcode encodings, opcode field placement and the legal
//               DATA_WIDTH list shared by the alu_pipe sources.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_defs;

    localparam int OPCODE_WIDTH = 4;

    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_ADD  = 4'b0001;
    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_SUB  = 4'b0010;
    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_ADDI = 4'b1001;
    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_SUBI = 4'b1010;
    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_SET  = 4'b0011;
    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_AND  = 4'b0101;
    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_OR   = 4'b0110;
    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_XOR  = 4'b0111;

    localparam int LEGAL_WIDTH_COUNT = 3;
    localparam int LEGAL_DATA_WIDTHS [LEGAL_WIDTH_COUNT] = '{16, 32, 48};

    // Opcode occupies the top OPCODE_WIDTH bits of the action word.
    function automatic int opcode_lsb(input int action_len);
        return action_len - OPCODE_WIDTH;
    endfunction

    function automatic bit is_legal_data_width(input int width);
        for (int i = 0; i < LEGAL_WIDTH_COUNT; i++) begin
            if (width == LEGAL_DATA_WIDTHS[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : alu_delay_line
// Description : DEPTH-stage register chain with a valid bit per stage, a
//               common enable and synchronous clear; DEPTH=0 is a wire.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused_ctrl;
        assign w_unused_ctrl = ^{clk, rst, i_en};
        assign o_valid       = i_valid;
        assign o_data        = i_data;
    end else begin : g_chain
        logic [DEPTH-1:0] r_valid;
        logic [WIDTH-1:0] r_data [DEPTH];

        // Invalid entries still shift; no bubble collapsing.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= '0;
                for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
            end else if (i_en) begin
                r_valid[0] <= i_valid;
                r_data[0]  <= i_data;
                for (int i = 1; i < DEPTH; i++) begin
                    r_valid[i] <= r_valid[i-1];
                    r_data[i]  <= r_data[i-1];
                end
            end
        end

        assign o_valid = r_valid[DEPTH-1];
        assign o_data  = r_data[DEPTH-1];
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Pipelined type-1 RMT ALU with global-stall backpressure.
//               Optional macro ALU_SATURATE_EN clamps add/sub on carry/borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_defs::*;
#(
    parameter int STAGE      = 0,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48,
    parameter int IMM_WIDTH  = 16,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_valid,
    output logic                  action_ready,
    input  logic [DATA_WIDTH-1:0] operand_1_in,
    input  logic [DATA_WIDTH-1:0] operand_2_in,
    output logic [DATA_WIDTH-1:0] container_out,
    output logic                  container_out_ovf,
    output logic                  container_out_valid,
    input  logic                  container_out_ready
);

    localparam int c_op_lsb = opcode_lsb(ACTION_LEN);

    if (!is_legal_data_width(DATA_WIDTH)) begin : g_bad_data_width
        $error("alu_pipe: DATA_WIDTH must be 16, 32 or 48");
    end
    if (ACTION_LEN < 20 || IMM_WIDTH > DATA_WIDTH || STAGE < 0) begin : g_bad_fields
        $error("alu_pipe: illegal ACTION_LEN/IMM_WIDTH/STAGE");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("alu_pipe: LATENCY must be in 1..8");
    end

    logic                    w_stall;
    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [DATA_WIDTH-1:0]   w_imm;
    logic [DATA_WIDTH-1:0]   w_arith_b;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_diff;
    logic [DATA_WIDTH-1:0]   w_result;
    logic                    w_ovf;
    logic                    w_unused_action;

    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_result;
    logic                    r_s1_ovf;
    logic [DATA_WIDTH:0]     w_out_data;

    assign w_stall         = container_out_valid && !container_out_ready;
    assign action_ready    = !w_stall;
    assign w_opcode        = action_in[c_op_lsb +: OPCODE_WIDTH];
    assign w_imm           = DATA_WIDTH'(action_in[IMM_WIDTH-1:0]);
    assign w_unused_action = ^action_in;

    // Opcode bit 3 selects the immediate form of add/sub.
    assign w_arith_b = w_opcode[3] ? w_imm : operand_2_in;
    assign w_sum     = {1'b0, operand_1_in} + {1'b0, w_arith_b};
    assign w_diff    = {1'b0, operand_1_in} - {1'b0, w_arith_b};

    always_comb begin
        w_result = operand_1_in;
        w_ovf    = 1'b0;
        case (w_opcode)
            ALU_OP_ADD, ALU_OP_ADDI: begin
                w_result = w_sum[DATA_WIDTH-1:0];
                w_ovf    = w_sum[DATA_WIDTH];
`ifdef ALU_SATURATE_EN
                if (w_sum[DATA_WIDTH]) w_result = '1;
`endif
            end
            ALU_OP_SUB, ALU_OP_SUBI: begin
                w_result = w_diff[DATA_WIDTH-1:0];
                w_ovf    = w_diff[DATA_WIDTH];
`ifdef ALU_SATURATE_EN
                if (w_diff[DATA_WIDTH]) w_result = '0;
`endif
            end
            ALU_OP_SET: w_result = w_imm;
            ALU_OP_AND: w_result = operand_1_in & operand_2_in;
            ALU_OP_OR:  w_result = operand_1_in | operand_2_in;
            ALU_OP_XOR: w_result = operand_1_in ^ operand_2_in;
            default:    w_result = operand_1_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_result <= '0;
            r_s1_ovf    <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid  <= action_valid;
            r_s1_result <= w_result;
            r_s1_ovf    <= w_ovf;
        end
    end

    alu_delay_line #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (LATENCY - 1)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_en    (!w_stall),
        .i_valid (r_s1_valid),
        .i_data  ({r_s1_ovf, r_s1_result}),
        .o_valid (container_out_valid),
        .o_data  (w_out_data)
    );

    assign container_out_ovf = w_out_data[DATA_WIDTH];
    assign container_out     = w_out_data[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Directed self-checking bench for alu_pipe (LATENCY 3, 1, 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int AL = 25;
    localparam int DW = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic [AL-1:0] action_in;
    logic          action_valid;
    logic          action_valid_1;
    logic          action_valid_8;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic          co_ready;
    logic          co_ready_fixed;

    logic          ar3, ar1, ar8;
    logic [DW-1:0] out3, out1, out8;
    logic          ovf3, ovf1, ovf8;
    logic          v3, v1, v8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_pipe #(.LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .action_in(action_in), .action_valid(action_valid),
        .action_ready(ar3), .operand_1_in(op1), .operand_2_in(op2),
        .container_out(out3), .container_out_ovf(ovf3),
        .container_out_valid(v3), .container_out_ready(co_ready)
    );

    alu_pipe #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .action_in(action_in), .action_valid(action_valid_1),
        .action_ready(ar1), .operand_1_in(op1), .operand_2_in(op2),
        .container_out(out1), .container_out_ovf(ovf1),
        .container_out_valid(v1), .container_out_ready(co_ready_fixed)
    );

    alu_pipe #(.LATENCY(8)) dut8 (
        .clk(clk), .rst(rst), .action_in(action_in), .action_valid(action_valid_8),
        .action_ready(ar8), .operand_1_in(op1), .operand_2_in(op2),
        .container_out(out8), .container_out_ovf(ovf8),
        .container_out_valid(v8), .container_out_ready(co_ready_fixed)
    );

    function automatic logic [AL-1:0] act(input logic [3:0] op, input logic [15:0] imm);
        return {op, 5'b0, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d, input logic o);
        chk({tag, "_valid"}, 64'(v3), 64'(v));
        chk({tag, "_data"}, 64'(out3), 64'(d));
        chk({tag, "_ovf"}, 64'(ovf3), 64'(o));
    endtask

    logic [3:0]    t_ops  [8] = '{4'b0011, 4'b0011, 4'b0111, 4'b0101, 4'b0110, 4'b1111, 4'b0001, 4'b1010};
    logic [15:0]   t_imms [8] = '{16'h0000, 16'h0007, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0234};
    logic [DW-1:0] t_exp  [8] = '{48'h0, 48'h7, 48'h0F00FF0012CB, 48'h00F000F00034,
                                  48'h0FF0FFF012FF, 48'h00F0F0F01234, 48'h10E100E01333,
                                  48'h00F0F0F01000};

    initial begin
        rst = 1'b1; action_in = '0; action_valid = 1'b0;
        action_valid_1 = 1'b0; action_valid_8 = 1'b0;
        op1 = '0; op2 = '0; co_ready = 1'b1; co_ready_fixed = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk_out("reset", 1'b0, '0, 1'b0);
        chk("reset_ready", 64'(ar3), 64'd1);

        // Single add, LATENCY 3
        action_in = act(4'b0001, 16'h0); op1 = 48'h10; op2 = 48'h20; action_valid = 1'b1;
        step();
        action_valid = 1'b0;
        chk("add_lat_e0", 64'(v3), 64'd0);
        step();
        chk("add_lat_e1", 64'(v3), 64'd0);
        step();
        chk_out("add", 1'b1, 48'h30, 1'b0);
        step();
        chk("add_pulse", 64'(v3), 64'd0);

        // Carry and borrow
        action_in = act(4'b1001, 16'h0002); op1 = 48'hFFFF_FFFF_FFFF; action_valid = 1'b1;
        step();
        action_in = act(4'b0010, 16'h0); op1 = 48'h0; op2 = 48'h1;
        step();
        action_valid = 1'b0;
        step();
`ifdef ALU_SATURATE_EN
        chk_out("addi_carry", 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1);
        step();
        chk_out("sub_borrow", 1'b1, 48'h0, 1'b1);
`else
        chk_out("addi_carry", 1'b1, 48'h1, 1'b1);
        step();
        chk_out("sub_borrow", 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1);
`endif
        step();
        chk("ovf_drain", 64'(v3), 64'd0);

        // Eight back-to-back actions
        op1 = 48'h00F0F0F01234; op2 = 48'h0FF00FF000FF;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                action_in = act(t_ops[i], t_imms[i]);
                action_valid = 1'b1;
            end else begin
                action_valid = 1'b0;
            end
            step();
            if (i >= 2) chk_out($sformatf("thru%0d", i - 2), 1'b1, t_exp[i-2], 1'b0);
        end
        step();
        chk("thru_drain", 64'(v3), 64'd0);

        // Backpressure: four stalled edges with a new action held at the input
        action_in = act(4'b0011, 16'h0011); action_valid = 1'b1;
        step();
        action_in = act(4'b0011, 16'h0022);
        step();
        action_in = act(4'b0011, 16'h0033);
        step();
        co_ready = 1'b0;
        action_in = act(4'b0011, 16'h0044);
        #1;
        chk("stall_ready0", 64'(ar3), 64'd0);
        chk_out("stall_a0", 1'b1, 48'h11, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("stall_ready%0d", k), 64'(ar3), 64'd0);
            chk_out($sformatf("stall_a%0d", k), 1'b1, 48'h11, 1'b0);
        end
        co_ready = 1'b1;
        #1;
        chk("release_ready", 64'(ar3), 64'd1);
        step();
        action_valid = 1'b0;
        chk_out("release_b", 1'b1, 48'h22, 1'b0);
        step();
        chk_out("release_c", 1'b1, 48'h33, 1'b0);
        step();
        chk_out("release_d", 1'b1, 48'h44, 1'b0);
        step();
        chk("release_nodup", 64'(v3), 64'd0);

        // Reset with entries in flight
        action_in = act(4'b0011, 16'h0099); action_valid = 1'b1;
        step();
        action_in = act(4'b0011, 16'h00AA);
        step();
        action_in = act(4'b0011, 16'h00BB); rst = 1'b1;
        step();
        rst = 1'b0; action_valid = 1'b0;
        chk_out("midrst", 1'b0, '0, 1'b0);
        chk("midrst_ready", 64'(ar3), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("midrst_quiet%0d", k), 64'(v3), 64'd0);
        end

        // Latency sweep on LATENCY=1 and LATENCY=8 instances
        action_in = act(4'b0001, 16'h0); op1 = 48'h10; op2 = 48'h20;
        action_valid_1 = 1'b1; action_valid_8 = 1'b1;
        step();
        action_valid_1 = 1'b0; action_valid_8 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) step();
            chk($sformatf("lat1_valid_c%0d", k + 1), 64'(v1), 64'(k == 0));
            chk($sformatf("lat8_valid_c%0d", k + 1), 64'(v8), 64'(k == 7));
            if (k == 0) chk("lat1_data", 64'(out1), 64'h30);
            if (k == 7) chk("lat8_data", 64'(out8), 64'h30);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
